pipe_control: RTL

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 101 ++++++++++
 1 files changed

// File: rtl/pipe_control.sv
// Pipeline interlock controller: stage occupancy, stall chain, update enables,
// operand forwarding selection and a saturating decode-stall counter.
module pipe_control #(
    parameter int STAGES = 5,
    parameter int AW     = 5,
    localparam int NSRC  = STAGES - 2,
    localparam int SW    = $clog2(NSRC + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    input  logic                 rs_used,
    input  logic                 rt_used,
    input  logic [NSRC*AW-1:0]   src_cad,
    input  logic [NSRC-1:0]      src_we,
    input  logic [NSRC-1:0]      src_rdy,
    input  logic [STAGES-1:0]    ext_haz,
    input  logic                 flush,
    output logic [STAGES-1:0]    full,
    output logic [STAGES-1:0]    ue,
    output logic [SW-1:0]        fwd_a,
    output logic [SW-1:0]        fwd_b,
    output logic [15:0]          stall_cnt
);

    logic [STAGES-1:0] full_q, full_d;
    logic [STAGES-1:0] haz, stall;
    logic [SW-1:0]     sel_a, sel_b;
    logic              hit_a, hit_b, rdy_a, rdy_b, dhaz;
    logic [15:0]       stall_cnt_q;

    // Descending scan so the lowest-index matching source wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        for (int j = NSRC - 1; j >= 0; j--) begin
            if (full_q[j+2] && src_we[j]) begin
                if (rs_used && rs != '0 && src_cad[j*AW +: AW] == rs) begin
                    sel_a = SW'(j + 1);
                    hit_a = 1'b1;
                    rdy_a = src_rdy[j];
                end
                if (rt_used && rt != '0 && src_cad[j*AW +: AW] == rt) begin
                    sel_b = SW'(j + 1);
                    hit_b = 1'b1;
                    rdy_b = src_rdy[j];
                end
            end
        end
        dhaz = (hit_a & ~rdy_a) | (hit_b & ~rdy_b);
    end

    always_comb begin
        haz    = ext_haz;
        haz[1] = ext_haz[1] | dhaz;
        stall  = '0;
        stall[STAGES-1] = full_q[STAGES-1] & haz[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            stall[i] = (haz[i] | stall[i+1]) & full_q[i];
        end
    end

    always_comb begin
        ue    = rst ? (full_q & ~stall) : '0;
        ue[1] = ue[1] & ~flush;
        fwd_a = rst ? sel_a : '0;
        fwd_b = rst ? sel_b : '0;
    end

    always_comb begin
        full_d    = full_q;
        full_d[0] = 1'b1;
        for (int i = 1; i < STAGES; i++) begin
            full_d[i] = ue[i-1] | stall[i];
        end
        if (flush) begin
            full_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q      <= {{(STAGES-1){1'b0}}, 1'b1};
            stall_cnt_q <= 16'd0;
        end else begin
            full_q <= full_d;
            if (stall[1] && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign full      = full_q;
    assign stall_cnt = stall_cnt_q;

endmodule
